// File: rtl/operand_pair_if.sv
// operand_pair_if
//   Bundles the serial-bit input handshake, the operand-pair output handshake,
//   the synchronous flush and the occupancy level of operand_pair_feeder.
//   slave  : the feeder's view (consumes bits, produces pairs)
//   master : the environment's view (produces bits, consumes pairs)
// Signals:
//   flush      : synchronous clear of FIFO and assembler
//   bit_in     : serial operand bit
//   bit_valid  : bit_in is valid this cycle
//   bit_ready  : feeder accepts bit_in this cycle
//   data1_out  : first bit of the head pair
//   data2_out  : second bit of the head pair
//   valid_out  : head pair is valid
//   ready_in   : downstream accepts the head pair
//   level      : number of stored pairs, 0..DEPTH
interface operand_pair_if #(
    parameter int DEPTH = 4
) ();
    logic                           flush;
    logic                           bit_in;
    logic                           bit_valid;
    logic                           bit_ready;
    logic                           data1_out;
    logic                           data2_out;
    logic                           valid_out;
    logic                           ready_in;
    logic [$clog2(DEPTH+1)-1:0]     level;

    modport slave (
        input  flush, bit_in, bit_valid, ready_in,
        output bit_ready, data1_out, data2_out, valid_out, level
    );

    modport master (
        output flush, bit_in, bit_valid, ready_in,
        input  bit_ready, data1_out, data2_out, valid_out, level
    );
endinterface

// File: rtl/operand_pair_feeder.sv
// operand_pair_feeder
//   Assembles a serial bit stream into operand pairs {data1, data2} and
//   buffers them in a DEPTH-entry show-ahead FIFO feeding the adder stage
//   through a valid/ready handshake.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   pair_if  : operand_pair_if.slave (bit input handshake, pair output
//              handshake, flush, level)
module operand_pair_feeder #(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    operand_pair_if.slave   pair_if
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_hold;
    logic [1:0]     r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [LW-1:0]  r_count;

    logic           w_full;
    logic           w_empty;
    logic           w_bit_ready;
    logic           w_accept;
    logic           w_push;
    logic           w_pop;

    assign w_full   = (r_count == LW'(DEPTH));
    assign w_empty  = (r_count == {LW{1'b0}});
    assign w_accept = pair_if.bit_valid & w_bit_ready;
    assign w_push   = w_accept & (r_state == ST_SECOND);
    assign w_pop    = (~w_empty) & pair_if.ready_in;

    // bit_ready from registered state only: a pop in the same cycle does not
    // free a slot for the completing bit, keeping ready_in off this path.
    always_comb begin
        w_bit_ready = 1'b1;
        case (r_state)
            ST_FIRST:  w_bit_ready = 1'b1;
            ST_SECOND: w_bit_ready = ~w_full;
            default:   w_bit_ready = 1'b1;
        endcase
    end

    // Assembler next state: advance only on an accepted bit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FIRST: begin
                if (w_accept) begin
                    w_state_nxt = ST_SECOND;
                end else begin
                    w_state_nxt = ST_FIRST;
                end
            end
            ST_SECOND: begin
                if (w_accept) begin
                    w_state_nxt = ST_FIRST;
                end else begin
                    w_state_nxt = ST_SECOND;
                end
            end
            default: w_state_nxt = ST_FIRST;
        endcase
    end

    // Assembler state and hold register; flush discards a half-built pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FIRST;
            r_hold  <= 1'b0;
        end else if (pair_if.flush) begin
            r_state <= ST_FIRST;
            r_hold  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && (r_state == ST_FIRST)) begin
                r_hold <= pair_if.bit_in;
            end
        end
    end

    // FIFO storage, pointers and occupancy; flush leaves memory contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 2'b00;
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {LW{1'b0}};
        end else if (pair_if.flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {LW{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {r_hold, pair_if.bit_in};
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Show-ahead head; a consumed entry is not re-zeroed.
    assign pair_if.data1_out = r_mem[r_rd_ptr][1];
    assign pair_if.data2_out = r_mem[r_rd_ptr][0];
    assign pair_if.valid_out = ~w_empty;
    assign pair_if.bit_ready = w_bit_ready;
    assign pair_if.level     = r_count;
endmodule

// File: tb/tb_operand_pair_feeder.sv
// tb_operand_pair_feeder
//   Self-checking bench for operand_pair_feeder (DEPTH=4). A bench-side model
//   (assembler state, hold bit, queue of expected pairs) is stepped once per
//   clock from the driven stimulus; expected pairs are pushed when their
//   second bit is driven and accepted, and popped/compared as the DUT hands
//   them downstream.
module tb_operand_pair_feeder;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    operand_pair_if #(.DEPTH(DEPTH)) pif ();

    operand_pair_feeder #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .pair_if (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [1:0] sb_q[$];
    logic       m_second = 1'b0;
    logic       m_hold   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs (called just after a negedge), check the
    // current outputs against the model, clock, then update the model.
    task automatic step(input logic bv, input logic b, input logic rdy,
                        input logic fl, output logic acc);
        logic exp_rdy;
        logic pop;
        pif.bit_valid = bv;
        pif.bit_in    = b;
        pif.ready_in  = rdy;
        pif.flush     = fl;
        #1;
        exp_rdy = (!m_second) || (sb_q.size() < DEPTH);
        check_eq("bit_ready", 32'(pif.bit_ready), 32'(exp_rdy));
        check_eq("valid_out", 32'(pif.valid_out), 32'(sb_q.size() != 0));
        check_eq("level", 32'(pif.level), 32'(sb_q.size()));
        check_eq("level_max", 32'(pif.level <= DEPTH), 32'd1);
        if (sb_q.size() != 0) begin
            check_eq("head_pair", 32'({pif.data1_out, pif.data2_out}), 32'(sb_q[0]));
        end
        acc = bv & exp_rdy;
        pop = (sb_q.size() != 0) & rdy;
        @(posedge clk);
        if (fl) begin
            sb_q.delete();
            m_second = 1'b0;
            m_hold   = 1'b0;
        end else begin
            if (pop) void'(sb_q.pop_front());
            if (acc) begin
                if (!m_second) begin
                    m_hold   = b;
                    m_second = 1'b1;
                end else begin
                    sb_q.push_back({m_hold, b});
                    m_second = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    // Offer one bit until accepted; rmode 0/1 fixes ready_in, 2 randomises it.
    task automatic send_bit(input logic b, input int rmode, output int tries);
        logic acc;
        logic rdy;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 20) begin
            rdy = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode);
            step(1'b1, b, rdy, 1'b0, acc);
            tries++;
        end
        if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n, input logic rdy);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rdy, 1'b0, acc);
    endtask

    task automatic reset_model();
        sb_q.delete();
        m_second = 1'b0;
        m_hold   = 1'b0;
    endtask

    initial begin
        int         tries;
        logic       acc;
        logic [9:0] fill_bits;
        logic [3:0] k;

        rst = 1'b1;
        pif.flush = 1'b0; pif.bit_in = 1'b0; pif.bit_valid = 1'b0; pif.ready_in = 1'b0;
        #3;
        check_eq("rst_bit_ready", 32'(pif.bit_ready), 32'd1);
        check_eq("rst_valid", 32'(pif.valid_out), 32'd0);
        check_eq("rst_data", 32'({pif.data1_out, pif.data2_out}), 32'd0);
        check_eq("rst_level", 32'(pif.level), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single pair 1,0 with ready_in high: valid for one cycle.
        step(1'b1, 1'b1, 1'b1, 1'b0, acc);
        check_eq("sp_level_after_b1", 32'(pif.level), 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, acc);
        #1;
        check_eq("sp_valid", 32'(pif.valid_out), 32'd1);
        check_eq("sp_pair", 32'({pif.data1_out, pif.data2_out}), 32'b10);
        check_eq("sp_level", 32'(pif.level), 32'd1);
        idle(1, 1'b1);
        check_eq("sp_valid_drop", 32'(pif.valid_out), 32'd0);
        idle(2, 1'b1);

        // Fill and back-pressure: 9 bits fill the FIFO, the 10th is held.
        fill_bits = 10'b1_0110_0101_1;
        for (int i = 0; i < 9; i++) send_bit(fill_bits[i], 0, tries);
        #1;
        check_eq("fill_level4", 32'(pif.level), 32'd4);
        check_eq("fill_not_ready", 32'(pif.bit_ready), 32'd0);
        step(1'b1, fill_bits[9], 1'b0, 1'b0, acc);
        check_eq("fill_10th_held", 32'(acc), 32'd0);
        send_bit(fill_bits[9], 1, tries);
        check_eq("fill_10th_delay", 32'(tries), 32'd2);
        idle(6, 1'b1);

        // Wrap-around: 12 pairs k -> {k[0], k[1]} under random back-pressure.
        for (int kk = 0; kk < 12; kk++) begin
            k = 4'(kk);
            send_bit(k[0], 2, tries);
            send_bit(k[1], 2, tries);
        end
        idle(8, 1'b1);
        check_eq("wrap_drained", 32'(pif.level), 32'd0);

        // Simultaneous push and pop with two pairs stored.
        send_bit(1'b0, 0, tries); send_bit(1'b1, 0, tries);
        send_bit(1'b1, 0, tries); send_bit(1'b0, 0, tries);
        send_bit(1'b1, 0, tries);
        step(1'b1, 1'b1, 1'b1, 1'b0, acc);
        #1;
        check_eq("pp_level", 32'(pif.level), 32'd2);
        check_eq("pp_head", 32'({pif.data1_out, pif.data2_out}), 32'b10);
        idle(4, 1'b1);

        // Flush with 3 pairs, FSM in SECOND, accept and ready_in all at once.
        for (int i = 0; i < 7; i++) send_bit(1'(i % 2), 0, tries);
        step(1'b1, 1'b0, 1'b1, 1'b1, acc);
        #1;
        check_eq("fl_valid", 32'(pif.valid_out), 32'd0);
        check_eq("fl_level", 32'(pif.level), 32'd0);
        check_eq("fl_bit_ready", 32'(pif.bit_ready), 32'd1);
        send_bit(1'b1, 1, tries);
        send_bit(1'b1, 1, tries);
        #1;
        check_eq("fl_new_pair", 32'({pif.data1_out, pif.data2_out}), 32'b11);
        idle(3, 1'b1);

        // Async reset mid-stream with 2 pairs stored and a half pair held.
        send_bit(1'b0, 0, tries); send_bit(1'b1, 0, tries);
        send_bit(1'b1, 0, tries); send_bit(1'b1, 0, tries);
        send_bit(1'b1, 0, tries);
        pif.bit_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_valid", 32'(pif.valid_out), 32'd0);
        check_eq("ar_level", 32'(pif.level), 32'd0);
        check_eq("ar_bit_ready", 32'(pif.bit_ready), 32'd1);
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        send_bit(1'b0, 1, tries);
        send_bit(1'b0, 1, tries);
        #1;
        check_eq("ar_new_pair", 32'({pif.data1_out, pif.data2_out}), 32'b00);
        check_eq("ar_new_level", 32'(pif.level), 32'd1);
        idle(3, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/operand_pair_feeder.md
# operand_pair_feeder

Upstream stage for the registered single-bit adder stage. Assembles a serial bit stream into operand pairs (data1, data2) and buffers them in a small FIFO. Presents pairs with a valid/ready handshake, so the adder stage consumes exactly one pair per accepted transfer. Downstream `ready_in` is driven by the adder stage's ready output, which is constant 1 in the current design; the block must still honour back-pressure.

## Interface
- `DEPTH`, 4: FIFO capacity in pairs; a power of two, ≥ 2.
- `clk` input 1: clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `flush` input 1: synchronous clear of the FIFO and the assembler.
- `bit_in` input 1: serial operand bit.
- `bit_valid` input 1: `bit_in` is valid this cycle.
- `bit_ready` output 1: block accepts `bit_in` this cycle.
- `data1_out` output 1: first bit of the head pair.
- `data2_out` output 1: second bit of the head pair.
- `valid_out` output 1: head pair is valid.
- `ready_in` input 1: downstream accepts the head pair.
- `level` output $clog2(DEPTH+1): number of stored pairs, 0..DEPTH.

## Operation
- **Accept and pop events:**
  - Accept = `bit_valid` & `bit_ready`.
  - Pop = `valid_out` & `ready_in`.
- **Assembler FSM**, two states: FIRST (reset state) and SECOND.
  - FIRST: `bit_ready`=1. On accept, latch `bit_in` into the hold register and go to SECOND.
  - SECOND: `bit_ready`=!full. On accept, push {hold, `bit_in`} into the FIFO and return to FIRST.
  - No accept leaves the state unchanged.
- **FIFO:**
  - Memory of DEPTH 2-bit entries, with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
  - `count` runs 0..DEPTH. full = (`count`==DEPTH); empty = (`count`==0).
  - Push and pop in the same cycle leave `count` unchanged and advance both pointers.
  - No combinational path from `ready_in` to `bit_ready`. When full in SECOND, a push is refused even if a pop occurs that same cycle; the push is accepted on the following cycle.
- **Outputs:**
  - `valid_out` = !empty.
  - `data1_out`/`data2_out` = mem[rd_ptr] (show-ahead). They are 0 when empty, because the memory resets to 0; a consumed entry is not re-zeroed, so the data outputs are don't-care when `valid_out`=0.
  - Head data must be stable while `valid_out`=1 and `ready_in`=0.
  - `level` = `count`.
- **flush:**
  - Has priority over accept and pop in the same cycle.
  - Sets the pointers and `count` to 0 and the FSM to FIRST.
  - Discards a half-assembled pair.
  - Memory contents are not cleared.
- **Reset values:** `bit_ready`=1, `valid_out`=0, `data1_out`=0, `data2_out`=0, `level`=0, FSM=FIRST, hold=0, all memory entries 0.
- **Reset mid-operation:** all state clears asynchronously; a pair held in the FIFO or hold register is lost without any output pulse.

## Timing
- **Latency:** the pair is pushed on the edge that accepts its second bit. `valid_out` rises in the cycle after that edge, so the first pair is visible 2 cycles after its first bit when the FIFO is empty.
- **Throughput:** 1 bit/cycle on input, i.e. at most one pair per 2 cycles; up to 1 pair/cycle on output.
- **Pop timing:** a pop takes effect at the clock edge. The new head appears the next cycle, or `valid_out` drops if the FIFO becomes empty.
- **`bit_ready` and `level`:** `bit_ready` depends only on registered state (FSM, `count`). `level` is registered-equivalent, with no combinational path from inputs.
- **Async reset:** assertion clears outputs immediately, without waiting for an edge. Deassertion is synchronous to `clk`, handled externally.

## Test plan
- **Single pair:** after reset, drive bits 1 then 0 with `bit_valid`=1 and `ready_in`=1.
  - Required: `valid_out`=1 for exactly one cycle, 2 cycles after the first bit, with `data1_out`=1 and `data2_out`=0.
  - `level` goes 0→1→0.
- **Fill and back-pressure:** `ready_in`=0 with DEPTH=4; stream 10 bits.
  - Required: `level` reaches 4; `bit_ready` drops in SECOND after the 9th bit is accepted; the 10th bit is held.
  - Raise `ready_in`: the 10th bit is accepted one cycle after the first pop.
  - The 5 pairs emerge in order.
- **Wrap-around:** push and pop 12 pairs with the pattern pair k = {k[0], k[1]}.
  - Required: the output sequence matches in order; `level` never exceeds 4.
- **Simultaneous push and pop at `count`=2:** required: `level` stays 2 and the head advances to the next pair.
- **Flush:** assert `flush` with 3 pairs stored and the FSM in SECOND, together with an accept and `ready_in`=1.
  - Required next cycle: `valid_out`=0, `level`=0, FSM=FIRST.
  - The next two bits 1,1 form pair {1,1}.
- **Async reset mid-stream:** assert `rst` between clock edges with 2 pairs stored.
  - Required: `valid_out`=0, `level`=0 and `bit_ready`=1 before the next edge.
  - After release, the first output pair comes only from new input.
